// File: rtl/spi_rx_pkg.sv
// Shared types for the SPI receive framer: FSM state encoding and the
// helper that selects the sampling clock edge from CPOL/CPHA.
package spi_rx_pkg;

    typedef enum logic [1:0] {
        RESYNC = 2'd0,
        IDLE   = 2'd1,
        ACTIVE = 2'd2,
        HOLD   = 2'd3
    } state_e;

    // Modes 0 and 3 sample on the rising sclk edge; modes 1 and 2 on the falling edge.
    function automatic bit sample_on_rise(input int cpol, input int cpha);
        return ((cpol ^ cpha) & 1) == 0;
    endfunction

endpackage

// File: rtl/spi_rx_framer_if.sv
// Packet output bundle of the SPI receive framer: FIFO head with valid/ready
// plus the status pulses. master = framer side, slave = consumer side.
interface spi_rx_framer_if #(
    parameter int CMD_WIDTH = 8,
    parameter int DATA_W    = 16
) ();
    logic [CMD_WIDTH-1:0] pkt_cmd;
    logic [DATA_W-1:0]    pkt_data;
    logic                 pkt_valid;
    logic                 pkt_ready;
    logic                 frame_err;
    logic                 overflow;
    logic                 busy;

    modport master (
        output pkt_cmd, pkt_data, pkt_valid, frame_err, overflow, busy,
        input  pkt_ready
    );

    modport slave (
        input  pkt_cmd, pkt_data, pkt_valid, frame_err, overflow, busy,
        output pkt_ready
    );
endinterface

// File: rtl/spi_rx_fifo.sv
// First-word fall-through packet FIFO; the head is always visible on dout_o
// while not empty. Pointers carry one extra wrap bit for full/empty.
module spi_rx_fifo #(
    parameter int W     = 24,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push_i,
    input  logic [W-1:0] din_i,
    input  logic         pop_i,
    output logic [W-1:0] dout_o,
    output logic         full_o,
    output logic         empty_o
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

    logic [W-1:0] mem_q [DEPTH];
    logic [AW:0]  wr_q;
    logic [AW:0]  rd_q;
    logic         do_push;
    logic         do_pop;

    assign empty_o = (wr_q == rd_q);
    assign full_o  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    assign dout_o  = mem_q[rd_q[AW-1:0]];
    assign do_pop  = pop_i & ~empty_o;
    // A push into a full FIFO lands in the slot the head is leaving this cycle.
    assign do_push = push_i & (~full_o | do_pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_q[AW-1:0]] <= din_i;
                wr_q <= wr_q + PTR_ONE;
            end
            if (do_pop) begin
                rd_q <= rd_q + PTR_ONE;
            end
        end
    end

endmodule

// File: rtl/spi_rx_framer.sv
// SPI slave receive framer: synchronises sclk/mosi/csb, shifts packets MSB first
// and queues them in a FWFT FIFO. Define SPI_RX_BURST_EN for multi-packet frames.
//
// state  | meaning
// RESYNC | after reset; wait for the synchroniser to settle and csb to go high
// IDLE   | no frame; waiting for csb low
// ACTIVE | shifting bits of the current packet
// HOLD   | packet captured, frame still open; further bits make it over-long
module spi_rx_framer
    import spi_rx_pkg::*;
#(
    parameter int PACKET_WIDTH = 24,
    parameter int CMD_WIDTH    = 8,
    parameter int SYNC_STAGES  = 2,
    parameter int FIFO_DEPTH   = 4,
    parameter int CPOL         = 0,
    parameter int CPHA         = 0
) (
    input  logic            sys_clk,
    input  logic            rst_n,
    input  logic            sclk,
    input  logic            mosi,
    input  logic            csb,
    spi_rx_framer_if.master pkt_if
);
    localparam int DATA_W = PACKET_WIDTH - CMD_WIDTH;
    localparam int CW     = $clog2(PACKET_WIDTH + 1);
    localparam int FW     = $clog2(SYNC_STAGES + 2);
    localparam logic [CW-1:0] LAST_BIT   = CW'(PACKET_WIDTH - 1);
    localparam logic [FW-1:0] FLUSH_LOAD = FW'(SYNC_STAGES + 1);
    localparam logic          SCLK_IDLE  = 1'(CPOL);
    localparam bit            RISE       = sample_on_rise(CPOL, CPHA);

    logic [SYNC_STAGES-1:0] sclk_sync_q, mosi_sync_q, csb_sync_q;
    logic sclk_prev_q, mosi_prev_q, csb_prev_q;
    logic sclk_s, mosi_s, csb_s, csb_rise, sample;

    state_e                  state_q, state_d;
    logic [PACKET_WIDTH-1:0] shift_q, shift_d;
    logic [CW-1:0]           bit_cnt_q, bit_cnt_d;
    logic [FW-1:0]           flush_q, flush_d;
    logic                    extra_q, extra_d;
    logic                    push_q, push_d;
    logic                    frame_err_q, frame_err_d;
    logic                    overflow_q, overflow_d;
    logic                    busy_q;

    logic [PACKET_WIDTH-1:0] fifo_dout;
    logic                    fifo_full, fifo_empty, pop;

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            sclk_sync_q <= {SYNC_STAGES{SCLK_IDLE}};
            mosi_sync_q <= '0;
            csb_sync_q  <= '1;
            sclk_prev_q <= SCLK_IDLE;
            mosi_prev_q <= 1'b0;
            csb_prev_q  <= 1'b1;
        end else begin
            sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], sclk};
            mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], mosi};
            csb_sync_q  <= {csb_sync_q[SYNC_STAGES-2:0], csb};
            sclk_prev_q <= sclk_sync_q[SYNC_STAGES-1];
            mosi_prev_q <= mosi_sync_q[SYNC_STAGES-1];
            csb_prev_q  <= csb_sync_q[SYNC_STAGES-1];
        end
    end

    // mosi is taken from the older flop so data changing on the sample edge itself
    // is never captured; a correctly configured master settles it half a period earlier.
    assign sclk_s   = sclk_sync_q[SYNC_STAGES-1];
    assign csb_s    = csb_sync_q[SYNC_STAGES-1];
    assign mosi_s   = mosi_prev_q;
    assign csb_rise = csb_s & ~csb_prev_q;
    assign sample   = RISE ? (sclk_s & ~sclk_prev_q) : (~sclk_s & sclk_prev_q);

    always_comb begin
        state_d     = state_q;
        shift_d     = shift_q;
        bit_cnt_d   = bit_cnt_q;
        flush_d     = flush_q;
        extra_d     = extra_q;
        push_d      = 1'b0;
        frame_err_d = 1'b0;
        case (state_q)
            RESYNC: begin
                if (flush_q != '0) begin
                    flush_d = flush_q - FW'(1);
                end else if (csb_s) begin
                    state_d = IDLE;
                end
            end
            IDLE: begin
                if (!csb_s) begin
                    state_d   = ACTIVE;
                    shift_d   = '0;
                    bit_cnt_d = '0;
                    extra_d   = 1'b0;
                end
            end
            ACTIVE: begin
                if (csb_rise) begin
                    frame_err_d = (bit_cnt_q != '0);
                    state_d     = IDLE;
                end else if (sample) begin
                    shift_d = {shift_q[PACKET_WIDTH-2:0], mosi_s};
                    if (bit_cnt_q == LAST_BIT) begin
                        push_d = 1'b1;
`ifdef SPI_RX_BURST_EN
                        bit_cnt_d = '0;
`else
                        bit_cnt_d = '0;
                        state_d   = HOLD;
`endif
                    end else begin
                        bit_cnt_d = bit_cnt_q + CW'(1);
                    end
                end
            end
            HOLD: begin
                if (csb_rise) begin
                    frame_err_d = extra_q;
                    state_d     = IDLE;
                end else if (sample) begin
                    extra_d = 1'b1;
                end
            end
            default: state_d = RESYNC;
        endcase
    end

    assign pop        = pkt_if.pkt_ready & ~fifo_empty;
    assign overflow_d = push_q & fifo_full & ~pop;

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= RESYNC;
            shift_q     <= '0;
            bit_cnt_q   <= '0;
            flush_q     <= FLUSH_LOAD;
            extra_q     <= 1'b0;
            push_q      <= 1'b0;
            frame_err_q <= 1'b0;
            overflow_q  <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            shift_q     <= shift_d;
            bit_cnt_q   <= bit_cnt_d;
            flush_q     <= flush_d;
            extra_q     <= extra_d;
            push_q      <= push_d;
            frame_err_q <= frame_err_d;
            overflow_q  <= overflow_d;
            busy_q      <= (state_d != IDLE);
        end
    end

    // shift_q still holds the completed packet in the cycle push_q is high.
    spi_rx_fifo #(
        .W     (PACKET_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (sys_clk),
        .rst_n   (rst_n),
        .push_i  (push_q),
        .din_i   (shift_q),
        .pop_i   (pop),
        .dout_o  (fifo_dout),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign pkt_if.pkt_cmd   = fifo_dout[PACKET_WIDTH-1 -: CMD_WIDTH];
    assign pkt_if.pkt_data  = fifo_dout[DATA_W-1:0];
    assign pkt_if.pkt_valid = ~fifo_empty;
    assign pkt_if.frame_err = frame_err_q;
    assign pkt_if.overflow  = overflow_q;
    assign pkt_if.busy      = busy_q;

endmodule

// File: tb/tb_spi_rx_framer.sv
// Bench for spi_rx_framer: four DUTs in SPI modes 0-3 share one frame generator,
// plus a mode-0 DUT fed mode-1 clocking to show a mis-set CPHA corrupts data.
module tb_spi_rx_framer;
    localparam int NDUT = 5;

    logic clk;
    logic rst_n;
    logic mosi;
    logic csb;
    logic ph0;
    logic ph1;
    logic sclk_w  [NDUT];
    logic ready   [NDUT];
    logic [7:0]  cmd_w  [NDUT];
    logic [15:0] data_w [NDUT];
    logic valid_w [NDUT];
    logic ferr_w  [NDUT];
    logic ovf_w   [NDUT];
    logic busy_w  [NDUT];

    logic [23:0] got_mem [NDUT][512];
    int          got_n    [NDUT];
    int          ferr_cnt [NDUT];
    int          ovf_cnt  [NDUT];

    int n_tests;
    int n_fail;

    typedef struct {
        logic [63:0] bits;
        int          nbits;
        int          exp_n;
        logic [23:0] exp_p0;
        int          exp_err;
    } vec_t;
    vec_t tbl [7];

    always #5 clk = ~clk;

    for (genvar m = 0; m < NDUT; m++) begin : g_dut
        localparam int CPOL_G = (m == 4) ? 0 : (m / 2);
        localparam int CPHA_G = (m == 4) ? 0 : (m % 2);
        spi_rx_framer_if #(.CMD_WIDTH(8), .DATA_W(16)) pif ();
        // ph0 = second half of a bit slot, ph1 = first half
        assign sclk_w[m] = (m == 4) ? ph1 : (1'(CPOL_G) ^ ((CPHA_G != 0) ? ph1 : ph0));
        assign pif.pkt_ready = ready[m];
        spi_rx_framer #(
            .PACKET_WIDTH (24),
            .CMD_WIDTH    (8),
            .SYNC_STAGES  (2),
            .FIFO_DEPTH   (4),
            .CPOL         (CPOL_G),
            .CPHA         (CPHA_G)
        ) u_dut (
            .sys_clk (clk),
            .rst_n   (rst_n),
            .sclk    (sclk_w[m]),
            .mosi    (mosi),
            .csb     (csb),
            .pkt_if  (pif.master)
        );
        assign cmd_w[m]   = pif.pkt_cmd;
        assign data_w[m]  = pif.pkt_data;
        assign valid_w[m] = pif.pkt_valid;
        assign ferr_w[m]  = pif.frame_err;
        assign ovf_w[m]   = pif.overflow;
        assign busy_w[m]  = pif.busy;
    end

    // Inputs only change just after posedge, so negedge values are what the next edge sees.
    always @(negedge clk) begin
        for (int m = 0; m < NDUT; m++) begin
            if (valid_w[m] && ready[m]) begin
                got_mem[m][got_n[m][8:0]] <= {cmd_w[m], data_w[m]};
                got_n[m] <= got_n[m] + 1;
            end
            if (ferr_w[m]) ferr_cnt[m] <= ferr_cnt[m] + 1;
            if (ovf_w[m])  ovf_cnt[m]  <= ovf_cnt[m] + 1;
        end
    end

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic chk_ne(input string nm, input int act, input int bad);
        n_tests++;
        if (act == bad) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h which must differ from 0x%0h", nm, act, bad);
        end
    endtask

    // Sends nbits MSB first at sys:sclk = 8:1; rst_at >= 0 pulses reset before that bit.
    task automatic send_frame(input logic [63:0] bits, input int nbits, input int rst_at);
        csb = 1'b0;
        wait_cyc(8);
        for (int i = 0; i < nbits; i++) begin
            if (i == rst_at) begin
                rst_n = 1'b0;
                wait_cyc(3);
                rst_n = 1'b1;
                wait_cyc(1);
            end
            mosi = bits[nbits-1-i];
            ph1 = 1'b1;
            wait_cyc(4);
            ph1 = 1'b0;
            ph0 = 1'b1;
            wait_cyc(4);
            ph0 = 1'b0;
        end
        wait_cyc(8);
        csb  = 1'b1;
        mosi = 1'b0;
        wait_cyc(12);
    endtask

    task automatic frame_check(input string nm, input logic [63:0] bits, input int nbits,
                               input int exp_n, input logic [23:0] e0, input logic [23:0] e1,
                               input int exp_err);
        int bn [4];
        int be [4];
        int bo [4];
        for (int m = 0; m < 4; m++) begin
            bn[m] = got_n[m];
            be[m] = ferr_cnt[m];
            bo[m] = ovf_cnt[m];
        end
        send_frame(bits, nbits, -1);
        wait_cyc(24);
        for (int m = 0; m < 4; m++) begin
            chk($sformatf("%s/m%0d/npk", nm, m), got_n[m] - bn[m], exp_n);
            if (exp_n > 0)
                chk($sformatf("%s/m%0d/pkt0", nm, m), int'(got_mem[m][bn[m][8:0]]), int'(e0));
            if (exp_n > 1)
                chk($sformatf("%s/m%0d/pkt1", nm, m), int'(got_mem[m][9'(bn[m] + 1)]), int'(e1));
            chk($sformatf("%s/m%0d/ferr", nm, m), ferr_cnt[m] - be[m], exp_err);
            chk($sformatf("%s/m%0d/ovf", nm, m), ovf_cnt[m] - bo[m], 0);
        end
    endtask

    initial begin
        logic [23:0] ovf_vals [5];
        logic [23:0] exp_q [$];
        logic [63:0] rbits;
        logic [23:0] r0, r1;
        int b4, nb, en, eerr, exp_ovf;
        int bn [4];
        int bo [4];

        clk = 1'b0; rst_n = 1'b0; csb = 1'b1; mosi = 1'b0; ph0 = 1'b0; ph1 = 1'b0;
        n_tests = 0; n_fail = 0;
        for (int m = 0; m < NDUT; m++) ready[m] = 1'b1;

        tbl[0] = '{64'hA51234,    24, 1, 24'hA51234, 0};
        tbl[1] = '{64'h1FFF,      13, 0, 24'h000000, 1};
        tbl[2] = '{64'h7FFFFF,    24, 1, 24'h7FFFFF, 0};
        tbl[3] = '{64'h000000,    24, 1, 24'h000000, 0};
        tbl[4] = '{64'hFFFFFF,    24, 1, 24'hFFFFFF, 0};
        tbl[5] = '{64'h0,          0, 0, 24'h000000, 0};
        tbl[6] = '{64'h1ABCDEF,   25, 1, 24'hD5E6F7, 1};

        wait_cyc(3);
        chk("rst_valid", int'(valid_w[0]), 0);
        chk("rst_ferr",  int'(ferr_w[0]), 0);
        chk("rst_ovf",   int'(ovf_w[0]), 0);
        chk("rst_busy",  int'(busy_w[0]), 0);
        chk("rst_cmd",   int'(cmd_w[0]), 0);
        chk("rst_data",  int'(data_w[0]), 0);
        rst_n = 1'b1;
        wait_cyc(10);
        for (int m = 0; m < 4; m++) chk($sformatf("idle_busy/m%0d", m), int'(busy_w[m]), 0);

        // All four modes on the reference frame; DUT 4 has CPHA mis-set.
        b4 = got_n[4];
        frame_check("mode_a51234", 64'hA51234, 24, 1, 24'hA51234, 24'h0, 0);
        chk("miscfg_npk", got_n[4] - b4, 1);
        chk_ne("miscfg_data", int'(got_mem[4][b4[8:0]]), 24'hA51234);

        for (int i = 0; i < 7; i++)
            frame_check($sformatf("tbl%0d", i), tbl[i].bits, tbl[i].nbits, tbl[i].exp_n,
                        tbl[i].exp_p0, 24'h0, tbl[i].exp_err);

        // Five frames with the consumer stalled; the fifth does not fit.
        ovf_vals = '{24'h100001, 24'h200002, 24'h300003, 24'h400004, 24'h500005};
        for (int m = 0; m < 4; m++) begin
            ready[m] = 1'b0;
            bn[m] = got_n[m];
            bo[m] = ovf_cnt[m];
        end
        exp_q = {};
        exp_ovf = 0;
        for (int f = 0; f < 5; f++) begin
            send_frame(64'(ovf_vals[f]), 24, -1);
            if (exp_q.size() < 4) exp_q.push_back(ovf_vals[f]);
            else exp_ovf++;
        end
        wait_cyc(10);
        for (int m = 0; m < 4; m++) begin
            chk($sformatf("ovf_cnt/m%0d", m), ovf_cnt[m] - bo[m], exp_ovf);
            chk($sformatf("ovf_held/m%0d", m), got_n[m] - bn[m], 0);
            chk($sformatf("ovf_valid/m%0d", m), int'(valid_w[m]), 1);
            ready[m] = 1'b1;
        end
        wait_cyc(20);
        for (int m = 0; m < 4; m++) begin
            chk($sformatf("drain_n/m%0d", m), got_n[m] - bn[m], exp_q.size());
            for (int k = 0; k < exp_q.size(); k++)
                chk($sformatf("drain/m%0d/%0d", m, k), int'(got_mem[m][9'(bn[m] + k)]), int'(exp_q[k]));
        end

`ifdef SPI_RX_BURST_EN
        frame_check("burst48", 64'h010001020002, 48, 2, 24'h010001, 24'h020002, 0);
`else
        frame_check("burst48", 64'h010001020002, 48, 1, 24'h010001, 24'h0, 1);
`endif

        // Random frames against the packet-count model.
        for (int t = 0; t < 30; t++) begin
            rbits = {$urandom, $urandom};
            case ($urandom_range(0, 3))
                0:       nb = $urandom_range(0, 60);
                1:       nb = 48;
                default: nb = 24;
            endcase
`ifdef SPI_RX_BURST_EN
            en   = nb / 24;
            eerr = (nb % 24 != 0) ? 1 : 0;
`else
            en   = (nb >= 24) ? 1 : 0;
            eerr = (nb != 0 && nb != 24) ? 1 : 0;
`endif
            r0 = 24'h0;
            r1 = 24'h0;
            if (en > 0) r0 = 24'(rbits >> (nb - 24));
            if (en > 1) r1 = 24'(rbits >> (nb - 48));
            frame_check($sformatf("rnd%0d_n%0d", t, nb), rbits, nb, en, r0, r1, eerr);
        end

        // Reset mid-frame at bit 10 with csb held low: rest of that frame is ignored.
        for (int m = 0; m < 4; m++) bn[m] = got_n[m];
        send_frame(64'hA5A5A5, 24, 10);
        wait_cyc(24);
        for (int m = 0; m < 4; m++) chk($sformatf("rst_mid/m%0d/npk", m), got_n[m] - bn[m], 0);
        frame_check("post_rst", 64'h7FFFFF, 24, 1, 24'h7FFFFF, 24'h0, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
